vt_charwriter: RTL
==================

# vt_charwriter

Terminal character engine that sits directly upstream of the video generator. It consumes a byte stream from the host/UART side. It writes printable characters into the 80x24 screen memory using the VT52-style address map, and handles CR/LF/BS. It owns and drives the cursor position (`curX`/`curY`) and the scroll origin (`topline`) that the video generator reads.

## Interface
- No parameters. The geometry is fixed at 80 columns x 24 rows.
- `clock`  in  1  system clock. The same clock as the video generator. Screen memory is dual-port; this block uses the write port.
- `reset`  in  1  synchronous, active-high.
- `char_valid`  in  1  input byte valid.
- `char_data`  in  8  input byte. Bit 7 is ignored.
- `char_ready`  out  1  block can accept a byte this cycle.
- `curX`  out  7  cursor column, 0..79.
- `curY`  out  5  cursor physical row, 0..23.
- `topline`  out  5  physical row that is displayed at the top of the screen, 0..23.
- `mem_we`  out  1  screen memory write strobe.
- `mem_addr`  out  11  screen memory write address.
- `mem_wdata`  out  8  screen memory write data.

## Operation
- **Handshake:** a byte is accepted on a rising `clock` when `char_valid && char_ready`. `char_ready` is high only in IDLE (and in ESC when that feature is enabled).
- **Address map:** for physical row Y and column X:
  - outside = (Y[4]&Y[3]) | X[6]
  - addr = outside ? {Y[0],2'b11,Y[2:1],Y[4:3],X[3:0]} : {Y[0],Y[4:1],X[5:0]}
- **Logical bottom row:** (topline+23) mod 24.
- **States:**
  - **CLEAR_ALL:** entered on reset. Issues 1920 writes of 0x20, rows 0..23 in order, columns 0..79 within each row. Then goes to IDLE.
  - **IDLE:** decodes the accepted byte (see below).
  - **FILL:** writes 0x20 from a start position to an end position within/through rows. Issues one write per cycle, then goes to IDLE.
  - **ESC:** present only with `VTW_ESC_EN`.
- **Byte decode in IDLE:**
  - 0x20..0x7E: write the byte at (curX,curY). curX increments, saturating at 79. At column 79, further characters overwrite column 79; there is no auto-wrap.
  - 0x0D (CR): curX=0.
  - 0x0A (LF): curY=(curY+1) mod 24. If curY was the logical bottom row, topline=(topline+1) mod 24, and FILL clears the new bottom row (the new curY), columns 0..79.
  - 0x08 (BS): curX-1 if curX>0.
  - 0x1B (ESC): goes to ESC if enabled, otherwise ignored.
  - 0x7F and all other control codes are ignored.
- **Arithmetic:** all row arithmetic is modulo 24. curX never exceeds 79 and curY/topline never exceed 23.

## Timing
- **Reset values:**
  - curX=0, curY=0, topline=0.
  - char_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - The state is CLEAR_ALL with counters at row 0, column 0.
- **CLEAR_ALL timing:** the first write (addr 0, data 0x20) is presented in the first cycle after `reset` deasserts. The 1920th write is at cycle 1920. `char_ready` goes high in cycle 1921.
- **Printable byte:** accepted in cycle N. In cycle N+1, `mem_we`=1 with the address computed from the pre-increment curX, and curX is updated. `char_ready` is high again in N+1, which allows one byte per cycle.
- **LF with scroll:** accepted in cycle N. curY and topline update in N+1. The FILL writes occupy N+1..N+80. `char_ready` is low from N+1 to N+80 and high at N+81.
- **Non-printing bytes:** no memory write. Cursor/topline update in N+1.
- `mem_we` is a single-cycle strobe per write. `mem_addr` and `mem_wdata` are valid whenever `mem_we`=1.
- **Reset mid-operation:** reset asserted during any state (including FILL or CLEAR_ALL) restores all reset values. CLEAR_ALL restarts from row 0, column 0.

## Configuration
- **`VTW_ESC_EN` defined:** VT52 escape sequences are supported. After ESC, the next accepted byte selects the action, then the block returns to IDLE:
  - 'A': up, stop at topline.
  - 'B': down, stop at the logical bottom row.
  - 'C': right, stop at 79.
  - 'D': left, stop at 0.
  - 'H': home, curX=0, curY=topline.
  - 'K': FILL from curX to 79 on curY.
  - 'J': FILL from curX on curY through column 79 of the logical bottom row.
  - Any other byte: discarded.
- **`VTW_ESC_EN` undefined:** there is no ESC state, and 0x1B is ignored like any other control code.

## Test plan
- Release reset -> exactly 1920 writes of 0x20. The first is addr 0x000 and the last is row 23 col 79. `char_ready`=1 at cycle 1921.
- Send 'A' (0x41) after clear -> one write addr 0x000 data 0x41; curX=1.
- Send 66 printable bytes from (0,0) -> col 64 writes addr 0x300 and col 65 writes addr 0x301. After 80 bytes curX=79 and further bytes rewrite addr 0x30F.
- Send 23 LFs -> curY=23, topline=0, no writes. The 24th LF -> curY=0, topline=1, 80 writes to row 0 (addr 0x000..0x03F, 0x300..0x30F). `char_ready` is low for 80 cycles.
- CR and BS -> curX=5 plus BS gives 4. BS at curX=0 stays 0. CR gives curX=0. No writes.
- With `VTW_ESC_EN` defined: curX=10, send ESC then 'K' -> 70 writes of 0x20 for cols 10..79. ESC 'H' -> curX=0, curY=topline.

Source files
------------

// File: rtl/vt_charwriter.sv
// rtl/vt_charwriter.sv - 80x24 VT52-style character writer feeding screen memory; optional escapes via VTW_ESC_EN
module vt_charwriter (
    input  logic        clock,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic [6:0]  curX,
    output logic [4:0]  curY,
    output logic [4:0]  topline,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [7:0]  mem_wdata
);

    localparam logic [6:0] LAST_COL = 7'd79;
    localparam logic [4:0] LAST_ROW = 5'd23;
    localparam logic [7:0] BLANK    = 8'h20;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
`ifdef VTW_ESC_EN
        ST_FILL  = 2'd2,
        ST_ESC   = 2'd3
`else
        ST_FILL  = 2'd2
`endif
    } state_t;

    // Physical (row, column) to screen memory address; columns 64..79 fold into the upper block.
    function automatic logic [10:0] map_addr(input logic [4:0] y, input logic [6:0] x);
        if ((y[4] & y[3]) | x[6])
            map_addr = {y[0], 2'b11, y[2:1], y[4:3], x[3:0]};
        else
            map_addr = {y[0], y[4:1], x[5:0]};
    endfunction

    function automatic logic [4:0] row_inc(input logic [4:0] y);
        row_inc = (y == LAST_ROW) ? 5'd0 : y + 5'd1;
    endfunction

    function automatic logic [4:0] row_dec(input logic [4:0] y);
        row_dec = (y == 5'd0) ? LAST_ROW : y - 5'd1;
    endfunction

    state_t      state, state_d;
    logic [6:0]  curx_d;
    logic [4:0]  cury_d, top_d;
    logic        we_d;
    logic [10:0] addr_d;
    logic [7:0]  wdata_d;

    // Fill walker: position of the next blank to write, the final position, and
    // a flag saying the write currently on the bus is the final one.
    logic [6:0]  fill_x, fx_d, end_x, ex_d;
    logic [4:0]  fill_y, fy_d, end_y, ey_d;
    logic        fill_last, last_d;

    // Fill request raised by byte decode; the first blank goes out in the same edge.
    logic        start_fill;
    logic [6:0]  sx, fex;
    logic [4:0]  sy, fey;

    logic [7:0]  c_in;
    logic        accept;
    logic [4:0]  bottom;

    assign c_in   = char_data & 8'h7F;
`ifdef VTW_ESC_EN
    assign char_ready = (state == ST_IDLE) || (state == ST_ESC);
`else
    assign char_ready = (state == ST_IDLE);
`endif
    assign accept = char_valid && char_ready;
    assign bottom = row_dec(topline);

    // State register and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_CLEAR;
            curX      <= 7'd0;
            curY      <= 5'd0;
            topline   <= 5'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 11'd0;
            mem_wdata <= 8'd0;
            fill_x    <= 7'd0;
            fill_y    <= 5'd0;
            end_x     <= LAST_COL;
            end_y     <= LAST_ROW;
            fill_last <= 1'b0;
        end else begin
            state     <= state_d;
            curX      <= curx_d;
            curY      <= cury_d;
            topline   <= top_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            fill_x    <= fx_d;
            fill_y    <= fy_d;
            end_x     <= ex_d;
            end_y     <= ey_d;
            fill_last <= last_d;
        end
    end

    // Next-state, cursor, fill walker and write-port decode.
    always_comb begin
        state_d    = state;
        curx_d     = curX;
        cury_d     = curY;
        top_d      = topline;
        we_d       = 1'b0;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        fx_d       = fill_x;
        fy_d       = fill_y;
        ex_d       = end_x;
        ey_d       = end_y;
        last_d     = fill_last;
        start_fill = 1'b0;
        sx         = 7'd0;
        sy         = curY;
        fex        = LAST_COL;
        fey        = curY;

        case (state)
            ST_CLEAR, ST_FILL: begin
                if (fill_last) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = map_addr(fill_y, fill_x);
                    wdata_d = BLANK;
                    fx_d    = (fill_x == LAST_COL) ? 7'd0 : fill_x + 7'd1;
                    fy_d    = (fill_x == LAST_COL) ? row_inc(fill_y) : fill_y;
                    last_d  = (fill_x == end_x) && (fill_y == end_y);
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    if (c_in >= 8'h20 && c_in <= 8'h7E) begin
                        we_d    = 1'b1;
                        addr_d  = map_addr(curY, curX);
                        wdata_d = c_in;
                        curx_d  = (curX == LAST_COL) ? LAST_COL : curX + 7'd1;
                    end else begin
                        case (c_in)
                            8'h0D: curx_d = 7'd0;
                            8'h0A: begin
                                cury_d = row_inc(curY);
                                if (curY == bottom) begin
                                    top_d      = row_inc(topline);
                                    start_fill = 1'b1;
                                    sx         = 7'd0;
                                    sy         = row_inc(curY);
                                    fex        = LAST_COL;
                                    fey        = row_inc(curY);
                                end
                            end
                            8'h08: if (curX != 7'd0) curx_d = curX - 7'd1;
`ifdef VTW_ESC_EN
                            8'h1B: state_d = ST_ESC;
`endif
                            default: ;
                        endcase
                    end
                end
            end

`ifdef VTW_ESC_EN
            ST_ESC: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    case (c_in)
                        8'h41: if (curY != topline) cury_d = row_dec(curY);
                        8'h42: if (curY != bottom) cury_d = row_inc(curY);
                        8'h43: if (curX != LAST_COL) curx_d = curX + 7'd1;
                        8'h44: if (curX != 7'd0) curx_d = curX - 7'd1;
                        8'h48: begin
                            curx_d = 7'd0;
                            cury_d = topline;
                        end
                        8'h4B: begin
                            start_fill = 1'b1;
                            sx         = curX;
                            sy         = curY;
                            fex        = LAST_COL;
                            fey        = curY;
                        end
                        8'h4A: begin
                            start_fill = 1'b1;
                            sx         = curX;
                            sy         = curY;
                            fex        = LAST_COL;
                            fey        = bottom;
                        end
                        default: ;
                    endcase
                end
            end
`endif

            default: state_d = ST_CLEAR;
        endcase

        if (start_fill) begin
            state_d = ST_FILL;
            we_d    = 1'b1;
            addr_d  = map_addr(sy, sx);
            wdata_d = BLANK;
            fx_d    = (sx == LAST_COL) ? 7'd0 : sx + 7'd1;
            fy_d    = (sx == LAST_COL) ? row_inc(sy) : sy;
            ex_d    = fex;
            ey_d    = fey;
            last_d  = (sx == fex) && (sy == fey);
        end
    end

endmodule
